// File: rtl/serial_compare_ctrl.sv
// -----------------------------------------------------------------------------
// serial_compare_ctrl
//
// Bit-serial magnitude comparator with a small control FSM. A start request
// seen in IDLE captures both operands. The operands are then compared one bit
// per cycle, MSB first. The first differing bit fixes the outcome, and the
// registered result flags are loaded in DONE together with a one-cycle done
// pulse.
//
// Configuration macro:
//   SERIAL_CMP_EARLY_EXIT_EN - when defined, COMPARE leaves for DONE in the
//                              same cycle the first differing bit is found.
//                              Equal operands still scan all WIDTH bits.
//                              When undefined, COMPARE always lasts WIDTH
//                              cycles.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst         in   asynchronous active-high reset
//   start       in   compare request, sampled only in IDLE
//   A_word      in   operand A [WIDTH], captured on accepted start
//   B_word      in   operand B [WIDTH], captured on accepted start
//   busy        out  high while in COMPARE
//   done        out  one-cycle pulse, flags updated this cycle
//   A_great_B   out  registered A > B
//   A_equals_B  out  registered A == B
//   A_less_B    out  registered A < B
//   bit_index   out  bit being compared this cycle (debug)
// -----------------------------------------------------------------------------
module serial_compare_ctrl #(
  parameter  int WIDTH = 8,
  localparam int IW    = (WIDTH > 1) ? $clog2(WIDTH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] A_word,
  input  logic [WIDTH-1:0] B_word,
  output logic             busy,
  output logic             done,
  output logic             A_great_B,
  output logic             A_equals_B,
  output logic             A_less_B,
  output logic [IW-1:0]    bit_index
);

`ifdef SERIAL_CMP_EARLY_EXIT_EN
  localparam bit EARLY_EXIT = 1'b1;
`else
  localparam bit EARLY_EXIT = 1'b0;
`endif

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPARE = 2'd1,
    S_DONE    = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;

  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [IW-1:0]    r_idx;
  logic             r_gt;
  logic             r_lt;
  logic             r_done;
  logic             r_flag_gt;
  logic             r_flag_eq;
  logic             r_flag_lt;

  logic             w_a_bit;
  logic             w_b_bit;
  logic             w_bit_gt;
  logic             w_bit_lt;
  logic             w_bit_eq;
  logic             w_last_bit;

  // 1-bit compare of the operand bit selected this cycle.
  assign w_a_bit    = r_a[r_idx];
  assign w_b_bit    = r_b[r_idx];
  assign w_bit_gt   = w_a_bit & ~w_b_bit;
  assign w_bit_lt   = ~w_a_bit & w_b_bit;
  assign w_bit_eq   = ~(w_a_bit ^ w_b_bit);
  assign w_last_bit = (r_idx == '0);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the values from before the edge, independent of block order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // NOTE: w_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) w_next = S_COMPARE;
      end
      S_COMPARE: begin
        // A differing bit seen here must be the first one, because an
        // earlier difference would already have forced the exit.
        if (w_last_bit || (EARLY_EXIT && !w_bit_eq)) w_next = S_DONE;
      end
      S_DONE: begin
        w_next = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // Datapath: operand capture, serial accumulation, result registers.
  // The reset clears the captured operands, so an aborted compare leaves
  // nothing behind.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a       <= '0;
      r_b       <= '0;
      r_idx     <= '0;
      r_gt      <= 1'b0;
      r_lt      <= 1'b0;
      r_done    <= 1'b0;
      r_flag_gt <= 1'b0;
      r_flag_eq <= 1'b0;
      r_flag_lt <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a   <= A_word;
            r_b   <= B_word;
            r_idx <= IW'(WIDTH - 1);
            r_gt  <= 1'b0;
            r_lt  <= 1'b0;
          end
        end
        S_COMPARE: begin
          // Accumulate only while still undecided. This is what makes the
          // first differing bit final.
          if (!r_gt && !r_lt) begin
            r_gt <= w_bit_gt;
            r_lt <= w_bit_lt;
          end
          if (!w_last_bit) r_idx <= r_idx - 1'b1;
        end
        S_DONE: begin
          r_flag_gt <= r_gt;
          r_flag_lt <= r_lt;
          r_flag_eq <= ~(r_gt | r_lt);
          r_done    <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign busy       = (r_state == S_COMPARE);
  assign done       = r_done;
  assign A_great_B  = r_flag_gt;
  assign A_equals_B = r_flag_eq;
  assign A_less_B   = r_flag_lt;
  assign bit_index  = r_idx;

endmodule
